demux_rr_sched: RTL and testbench
=================================

// Module: demux_rr_sched
// PURPOSE
//  Round-robin scheduler driving a 1-to-N demultiplexer datapath. Accepts words on a
//  valid/ready input stream, registers each word with a destination index, and presents
//  it on exactly one of N_OUT valid/ready output channels. Sits upstream of the demux
//  tree and owns the select lines and all per-output flow control.
// PARAMETERS
//  N_OUT   8   number of output channels (2..16)
//  DW      8   data width in bits
//  SW      $clog2(N_OUT)   select width (localparam, not overridable)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input word present
//  in_data    in   DW     input word
//  in_ready   out  1      scheduler can take a word this cycle
//  out_data   out  DW     registered word, shared by all channels
//  out_valid  out  N_OUT  one-hot (or zero) channel valid
//  out_ready  in   N_OUT  per-channel sink ready
//  sel        out  SW     registered destination index of held word
//  busy       out  1      holding register occupied
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, ptr=0, sel=0, out_data=0,
//   out_valid=0, busy=0; in_ready=1 after release. Reset mid-transfer drops held word.
//  FSM IDLE: in_ready=1, out_valid=0. in_valid=1 -> out_data<=in_data, sel<=ptr, ->HOLD.
//  FSM HOLD: busy=1; out_valid[sel]=1, all other bits 0. out_data/sel stable until taken.
//   Transfer = out_ready[sel] & out_valid[sel]; ptr<=sel+1, wrap N_OUT-1 -> 0.
//   in_ready = out_ready[sel] (combinational) -> back-to-back: transfer + in_valid loads
//   next word with sel<=new ptr, stays HOLD; transfer without in_valid -> IDLE.
//  out_ready of non-selected channels ignored (outside SKIP_BUSY_EN selection).
//  Latency: in_data accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
//  Throughput: 1 word/cycle when selected sinks stay ready.
//  Stall: out_ready[sel]=0 holds word indefinitely; no drop, no reorder, no timeout.
//  in_valid while in_ready=0: ignored, source must hold its word.
//  Words delivered in acceptance order; destinations strictly cyclic 0,1,..,N_OUT-1,0,...
// CONFIGURATION
//  SKIP_BUSY_EN defined: at load, sel<=first index i in ptr,ptr+1,.. (mod N_OUT) with
//   out_ready[i]=1; none ready -> sel<=ptr. ptr<=sel+1 after transfer, so skipped
//   channels are visited next round. Fixed priority from ptr; pure combinational scan.
//  Not defined: sel<=ptr unconditionally; strict round-robin, out_ready only gates handoff.
// TESTING
//  T1 reset: rst_n=0 mid-HOLD, async -> out_valid=0, busy=0, sel=0 same cycle; resume ptr=0.
//  T2 rotation: N_OUT=8, 10 words 0xA0..0xA9, all ready -> channels 0..7,0,1; 1 word/cycle.
//  T3 stall: word 0x55 to ch3, out_ready[3]=0 for 5 cycles -> out_valid=8'h08, data held,
//   in_ready=0; release -> transfer, next word to ch4.
//  T4 wrap/back-to-back: ptr=7, two words consecutive -> sel=7 then sel=0, no idle cycle.
//  T5 SKIP_BUSY_EN: ptr=2, out_ready=8'b0011_0000 -> sel=4; then ptr=5; all zero -> sel=ptr.
//  T6 ignore: in_valid during stall with new data 0x77 -> not captured until in_ready=1.

Source files
------------

// File: rtl/demux_rr_sched.sv
// ---------------------------------------------------------------------------
// demux_rr_sched
//  Round-robin scheduler in front of a 1-to-N_OUT demux tree. Takes one word
//  at a time from a valid/ready input stream, holds it in a single register
//  together with its destination index, and raises exactly one out_valid bit
//  until that channel's sink takes the word.
//
//  Optional build macro: SKIP_BUSY_EN
//   undefined (default): each word goes to the pointer channel; the channels
//                        are visited strictly in the order 0,1,..,N_OUT-1,0,...
//   defined            : at load time the first ready channel at or after the
//                        pointer is chosen (combinational scan). If no channel
//                        is ready, the pointer channel is chosen.
// ---------------------------------------------------------------------------
module demux_rr_sched #(
   parameter  int N_OUT = 8,
   parameter  int DW    = 8,
   localparam int SW    = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             in_ready,
   output logic [DW-1:0]    out_data,
   output logic [N_OUT-1:0] out_valid,
   input  logic [N_OUT-1:0] out_ready,
   output logic [SW-1:0]    sel,
   output logic             busy
);

   // Two-state controller: empty holding register or occupied one.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]    state;
   logic [SW-1:0] ptr;

   logic          sel_ready;
   logic          xfer;
   logic          load;
   logic [SW-1:0] sel_next_ptr;
   logic [SW-1:0] load_base;
   logic [SW-1:0] load_sel;

   // Next channel index after v, wrapping N_OUT-1 back to 0.
   function automatic logic [SW-1:0] idx_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      if (v == SW'(N_OUT - 1)) begin
         r = {SW{1'b0}};
      end else begin
         r = v + SW'(1);
      end
      return r;
   endfunction

   // One-hot decode of a channel index onto the N_OUT valid lines.
   function automatic logic [N_OUT-1:0] idx_onehot(input logic [SW-1:0] v);
      logic [N_OUT-1:0] r;
      r = {N_OUT{1'b0}};
      for (int i = 0; i < N_OUT; i++) begin
         r[i] = (v == SW'(i));
      end
      return r;
   endfunction

   // Handshake decode: transfer, input acceptance and pointer base for a load.
   always_comb begin
      sel_ready    = out_ready[sel];
      sel_next_ptr = idx_inc(sel);
      if (state == ST_HOLD) begin
         xfer     = sel_ready;
         in_ready = sel_ready;
      end else begin
         xfer     = 1'b0;
         in_ready = 1'b1;
      end
      load = in_valid & in_ready;
      // A back-to-back load sees the pointer as it will be after this transfer.
      if (xfer) begin
         load_base = sel_next_ptr;
      end else begin
         load_base = ptr;
      end
   end

`ifdef SKIP_BUSY_EN
   logic [SW:0] scan_idx;
   logic        scan_found;

   // Fixed-priority scan from the pointer for the first ready channel.
   always_comb begin
      load_sel   = load_base;
      scan_idx   = {(SW+1){1'b0}};
      scan_found = 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
         scan_idx = {1'b0, load_base} + (SW+1)'(i);
         if (scan_idx >= (SW+1)'(N_OUT)) begin
            scan_idx = scan_idx - (SW+1)'(N_OUT);
         end else begin
            scan_idx = scan_idx;
         end
         if (!scan_found && out_ready[scan_idx[SW-1:0]]) begin
            scan_found = 1'b1;
            load_sel   = scan_idx[SW-1:0];
         end else begin
            scan_found = scan_found;
         end
      end
   end
`else
   // Strict rotation: destination is always the pointer channel.
   always_comb begin
      load_sel = load_base;
   end
`endif

   // Holding register, destination index, channel valids and controller state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sel       <= {SW{1'b0}};
         out_data  <= {DW{1'b0}};
         out_valid <= {N_OUT{1'b0}};
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load) begin
                  out_data  <= in_data;
                  sel       <= load_sel;
                  out_valid <= idx_onehot(load_sel);
                  busy      <= 1'b1;
                  state     <= ST_HOLD;
               end else begin
                  out_valid <= {N_OUT{1'b0}};
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_HOLD: begin
               if (load) begin
                  // Transfer and reload in the same cycle: no bubble.
                  out_data  <= in_data;
                  sel       <= load_sel;
                  out_valid <= idx_onehot(load_sel);
                  busy      <= 1'b1;
                  state     <= ST_HOLD;
               end else if (xfer) begin
                  // sel and out_data keep their last values while idle.
                  out_valid <= {N_OUT{1'b0}};
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else begin
                  // Stall: word, index and valid held without limit.
                  state <= ST_HOLD;
               end
            end
            default: begin
               out_valid <= {N_OUT{1'b0}};
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   // Round-robin pointer advances past the channel that just took a word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= {SW{1'b0}};
      end else if (xfer) begin
         ptr <= sel_next_ptr;
      end else begin
         ptr <= ptr;
      end
   end

endmodule

// File: tb/tb_demux_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_demux_rr_sched
//  Directed bench for demux_rr_sched (N_OUT=8, DW=8). Inputs are driven and
//  outputs sampled 1 time unit after each rising edge. Expected values are
//  hand-computed constants. The channel-selection test follows SKIP_BUSY_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_rr_sched;

   localparam int N_OUT = 8;
   localparam int DW    = 8;
   localparam int SW    = 3;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic [DW-1:0]    in_data;
   logic             in_ready;
   logic [DW-1:0]    out_data;
   logic [N_OUT-1:0] out_valid;
   logic [N_OUT-1:0] out_ready;
   logic [SW-1:0]    sel;
   logic             busy;

   int n_chk  = 0;
   int n_fail = 0;

   demux_rr_sched #(.N_OUT(N_OUT), .DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_hold(input string tag, input logic [SW-1:0] exp_sel,
                             input logic [DW-1:0] exp_data);
      check_val({tag, "_sel"},   32'(sel),       32'(exp_sel));
      check_val({tag, "_valid"}, 32'(out_valid), 32'(8'h01 << exp_sel));
      check_val({tag, "_data"},  32'(out_data),  32'(exp_data));
      check_val({tag, "_busy"},  32'(busy),      32'(1'b1));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 8'h00;
      step();
      step();
      // Reset state
      check_val("rst_valid", 32'(out_valid), 32'h0);
      check_val("rst_busy",  32'(busy),      32'h0);
      check_val("rst_sel",   32'(sel),       32'h0);
      check_val("rst_data",  32'(out_data),  32'h0);
      rst_n = 1'b1;
      #1;
      check_val("rst_in_ready", 32'(in_ready), 32'h1);

      // T2 rotation: 10 words back-to-back, all sinks ready.
      out_ready = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hA0 + 8'(i);
         #1;
         check_val($sformatf("rot_in_ready%0d", i), 32'(in_ready), 32'h1);
         step();
         check_hold($sformatf("rot%0d", i), SW'(i % 8), 8'hA0 + 8'(i));
      end
      in_valid = 1'b0;
      step();
      check_val("rot_idle_valid", 32'(out_valid), 32'h0);
      check_val("rot_idle_busy",  32'(busy),      32'h0);
      // ptr is now 2; move it to 3 with one word on ch2.
      in_valid = 1'b1;
      in_data  = 8'h11;
      step();
      check_hold("pre3", 3'd2, 8'h11);
      in_valid = 1'b0;
      step();

      // T3 stall on ch3, with T6 new word 0x77 offered during the stall.
      in_valid = 1'b1;
      in_data  = 8'h55;
      step();
      check_hold("stall_load", 3'd3, 8'h55);
      out_ready = 8'hF7;
      in_data   = 8'h77;
      for (int c = 0; c < 5; c++) begin
         #1;
         check_val($sformatf("stall_in_ready%0d", c), 32'(in_ready), 32'h0);
         step();
         check_val($sformatf("stall_valid%0d", c), 32'(out_valid), 32'h08);
         check_val($sformatf("stall_data%0d", c),  32'(out_data),  32'h55);
      end
      out_ready = 8'hFF;
      #1;
      check_val("release_in_ready", 32'(in_ready), 32'h1);
      step();
      check_hold("after_stall", 3'd4, 8'h77);
      in_valid = 1'b0;
      step();
      check_val("after_stall_busy", 32'(busy), 32'h0);

      // ptr = 5: two words to move it to 7.
      in_valid = 1'b1;
      in_data  = 8'h30;
      step();
      check_hold("mv5", 3'd5, 8'h30);
      in_data = 8'h31;
      step();
      check_hold("mv6", 3'd6, 8'h31);
      in_valid = 1'b0;
      step();

      // T4 wrap, back-to-back from ptr 7.
      in_valid = 1'b1;
      in_data  = 8'hC7;
      step();
      check_hold("wrap7", 3'd7, 8'hC7);
      in_data = 8'hC8;
      step();
      check_hold("wrap0", 3'd0, 8'hC8);
      in_valid = 1'b0;
      step();
      check_val("wrap_idle_busy", 32'(busy), 32'h0);
      // ptr = 1: one word to bring it to 2.
      in_valid = 1'b1;
      in_data  = 8'h01;
      step();
      check_hold("mv1", 3'd1, 8'h01);
      in_valid = 1'b0;
      step();

      // T5 selection with ptr=2 and only ch4/ch5 ready.
      out_ready = 8'b0011_0000;
      in_valid  = 1'b1;
      in_data   = 8'hD0;
      step();
      in_valid = 1'b0;
`ifdef SKIP_BUSY_EN
      check_hold("skip_sel", 3'd4, 8'hD0);
      step();
      check_val("skip_idle_busy", 32'(busy), 32'h0);
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'hD1;
      step();
      check_hold("skip_none", 3'd5, 8'hD1);
`else
      check_hold("strict_sel", 3'd2, 8'hD0);
      #1;
      check_val("strict_in_ready", 32'(in_ready), 32'h0);
      out_ready = 8'hFF;
      step();
      check_val("strict_idle_busy", 32'(busy), 32'h0);
      out_ready = 8'h00;
      in_valid  = 1'b1;
      in_data   = 8'hD1;
      step();
      check_hold("strict_none", 3'd3, 8'hD1);
`endif
      in_valid = 1'b0;

      // T1 asynchronous reset while holding a stalled word.
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_valid", 32'(out_valid), 32'h0);
      check_val("arst_busy",  32'(busy),      32'h0);
      check_val("arst_sel",   32'(sel),       32'h0);
      check_val("arst_data",  32'(out_data),  32'h0);
      step();
      rst_n = 1'b1;
      out_ready = 8'hFF;
      in_valid  = 1'b1;
      in_data   = 8'hE0;
      step();
      check_hold("resume", 3'd0, 8'hE0);
      in_valid = 1'b0;
      step();
      check_val("resume_idle_valid", 32'(out_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
